// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment scan controller.
package seg7_pkg;

   localparam int unsigned NUM_DIGITS = 4;

   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [3:0] DIG_OFF   = 4'b1111;

   // {g,f,e,d,c,b,a} patterns for decimal digits 0..9
   localparam logic [6:0] SEG_PATTERNS [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   typedef enum logic {StIdle, StPending} buf_state_e;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Write port of the scan controller: valid/ready handshake carrying BCD digits and decimal points.
interface seg7_scan_ctrl_if;
   import seg7_pkg::*;

   logic                      wr_valid;
   logic                      wr_ready;
   logic [4*NUM_DIGITS-1:0]   wr_data;
   logic [NUM_DIGITS-1:0]     wr_dp;

   modport master (output wr_valid, output wr_data, output wr_dp, input wr_ready);
   modport slave  (input wr_valid, input wr_data, input wr_dp, output wr_ready);

endinterface

// File: rtl/seg7_decode.sv
// BCD nibble to 7-segment pattern; non-decimal values produce a blank digit.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern
);

   always_comb begin
      pattern = SEG_BLANK[6:0];
      if (nibble < 4'd10) pattern = SEG_PATTERNS[nibble];
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-aligned double buffering,
// brightness PWM and optional leading-zero blanking.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned DWELL = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   seg7_scan_ctrl_if.slave       wr,
   input  logic                  blank_lz,
   input  logic [2:0]            brightness,
   output logic [NUM_DIGITS-1:0] digits,
   output logic [7:0]            segments,
   output logic                  frame_done
);

   localparam int unsigned IdxW = $clog2(NUM_DIGITS);
   localparam int unsigned CntW = $clog2(DWELL);
   localparam int unsigned Step = DWELL / 8;
   localparam logic [CntW-1:0] CntMax  = CntW'(DWELL - 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

   if (((DWELL % 8) != 0) || (DWELL < 8)) begin : g_dwell_check
      $error("DWELL must be a multiple of 8 and at least 8");
   end

   logic [IdxW-1:0]         idx_q;
   logic [CntW-1:0]         cnt_q;
   logic [2:0]              bright_q;
   buf_state_e              buf_q, buf_d;
   logic [4*NUM_DIGITS-1:0] shadow_data_q, active_data_q;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, active_dp_q;
   logic [NUM_DIGITS-1:0]   digits_q;
   logic [7:0]              segments_q;

   logic                    dwell_end, accept, commit, lit, lz_blank;
   logic [3:0]              nibble;
   logic [6:0]              pattern;
   logic [NUM_DIGITS-1:0]   zero_hi;
   logic [31:0]             lit_limit;

   assign dwell_end  = (cnt_q == CntMax);
   assign frame_done = dwell_end && (idx_q == LastIdx);
   assign wr.wr_ready = (buf_q == StIdle);
   assign accept     = wr.wr_valid && wr.wr_ready;
   // Only a write already pending before this frame_done cycle is committed now.
   assign commit     = frame_done && (buf_q == StPending);

   always_comb begin
      buf_d = buf_q;
      case (buf_q)
         StIdle:    if (accept) buf_d = StPending;
         StPending: if (commit) buf_d = StIdle;
         default:   buf_d = StIdle;
      endcase
   end

   assign nibble = active_data_q[{idx_q, 2'b00} +: 4];

   seg7_decode u_decode (
      .nibble  (nibble),
      .pattern (pattern)
   );

   // zero_hi[k]: nibble k and every more significant nibble are zero
   always_comb begin
      zero_hi = '0;
      zero_hi[NUM_DIGITS-1] = (active_data_q[4*NUM_DIGITS-1 -: 4] == 4'd0);
      for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
         zero_hi[k] = zero_hi[k+1] && (active_data_q[4*k +: 4] == 4'd0);
      end
   end

   assign lz_blank  = blank_lz && (idx_q != '0) && zero_hi[idx_q];
   assign lit_limit = (32'(bright_q) + 32'd1) * Step;
   // bright_q is only refreshed at the end of counter 0, which is always lit anyway
   assign lit       = (cnt_q == '0) || (32'(cnt_q) < lit_limit);

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q         <= '0;
         cnt_q         <= '0;
         bright_q      <= '0;
         buf_q         <= StIdle;
         shadow_data_q <= '0;
         shadow_dp_q   <= '0;
         active_data_q <= '0;
         active_dp_q   <= '0;
         digits_q      <= DIG_OFF;
         segments_q    <= SEG_BLANK;
      end else begin
         buf_q <= buf_d;
         cnt_q <= dwell_end ? '0 : cnt_q + CntW'(1);
         if (dwell_end) idx_q <= (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
         if (cnt_q == '0) bright_q <= brightness;
         if (accept) begin
            shadow_data_q <= wr.wr_data;
            shadow_dp_q   <= wr.wr_dp;
         end
         if (commit) begin
            active_data_q <= shadow_data_q;
            active_dp_q   <= shadow_dp_q;
         end
         digits_q   <= lit ? ~(NUM_DIGITS'(1) << idx_q) : DIG_OFF;
         segments_q <= lit ? {active_dp_q[idx_q], (lz_blank ? 7'h00 : pattern)} : SEG_BLANK;
      end
   end

   assign digits   = digits_q;
   assign segments = segments_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DWELL=8: scan order, commit timing, blanking, PWM, reset.
module tb_seg7_scan_ctrl;

   localparam int unsigned DWELL = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       blank_lz;
   logic [2:0] brightness;
   logic [3:0] digits;
   logic [7:0] segments;
   logic       frame_done;

   int n_cmp  = 0;
   int n_fail = 0;

   seg7_scan_ctrl_if wr_if ();

   seg7_scan_ctrl #(.DWELL(DWELL)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr         (wr_if),
      .blank_lz   (blank_lz),
      .brightness (brightness),
      .digits     (digits),
      .segments   (segments),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks one 32-cycle frame; the next negedge must show digit 0 at counter 0.
   task automatic check_frame(input string tag, input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0, input int b0,
                              input int b_rest, input int switch_at, input logic [2:0] b_new);
      logic [7:0] segs [4];
      logic [3:0] one;
      logic [3:0] exp_dig;
      logic [7:0] exp_seg;
      int         d, c, b;
      segs[0] = s0;
      segs[1] = s1;
      segs[2] = s2;
      segs[3] = s3;
      one     = 4'b0001;
      for (int k = 0; k < 32; k++) begin
         d = k / 8;
         c = k % 8;
         b = (d == 0) ? b0 : b_rest;
         exp_dig = (c < b + 1) ? ~(one << d) : 4'b1111;
         exp_seg = (c < b + 1) ? segs[d] : 8'h00;
         @(negedge clk);
         chk($sformatf("%s digits k=%0d", tag, k), digits, exp_dig);
         chk($sformatf("%s segments k=%0d", tag, k), segments, exp_seg);
         chk($sformatf("%s frame_done k=%0d", tag, k), frame_done, (k == 30));
         if (k == switch_at) brightness = b_new;
      end
   endtask

   // Stops on the negedge where frame_done is high.
   task automatic sync_frame(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_done !== 1'b1 && n < 100);
      chk({tag, " frame_done_seen"}, frame_done, 1'b1);
   endtask

   task automatic do_write(input string tag, input logic [15:0] data, input logic [3:0] dp);
      chk({tag, " ready_before"}, wr_if.wr_ready, 1'b1);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = data;
      wr_if.wr_dp    = dp;
      @(negedge clk);
      wr_if.wr_valid = 1'b0;
      chk({tag, " ready_after"}, wr_if.wr_ready, 1'b0);
   endtask

   initial begin
      rst            = 1'b1;
      blank_lz       = 1'b0;
      brightness     = 3'd7;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_data  = 16'h0000;
      wr_if.wr_dp    = 4'b0000;

      // Reset state and plain scan of all-zero digits
      @(negedge clk);
      chk("rst digits", digits, 4'b1111);
      chk("rst segments", segments, 8'h00);
      chk("rst wr_ready", wr_if.wr_ready, 1'b1);
      chk("rst frame_done", frame_done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      check_frame("t1_f0", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 7, 7, -1, 3'd7);
      check_frame("t1_f1", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 7, 7, -1, 3'd7);

      // Mid-frame write commits at frame_done
      do_write("t2", 16'h1234, 4'b0001);
      sync_frame("t2");
      chk("t2 ready_hold", wr_if.wr_ready, 1'b0);
      @(negedge clk);
      chk("t2 ready_back", wr_if.wr_ready, 1'b1);
      check_frame("t2", 8'h06, 8'h5B, 8'h4F, 8'hE6, 7, 7, -1, 3'd7);

      // Leading-zero blanking
      blank_lz = 1'b1;
      do_write("t3a", 16'h0007, 4'b0000);
      sync_frame("t3a");
      @(negedge clk);
      check_frame("t3a", 8'h00, 8'h00, 8'h00, 8'h07, 7, 7, -1, 3'd7);
      do_write("t3b", 16'h0000, 4'b0000);
      sync_frame("t3b");
      @(negedge clk);
      check_frame("t3b", 8'h00, 8'h00, 8'h00, 8'h3F, 7, 7, -1, 3'd7);
      do_write("t3c", 16'h0A05, 4'b0000);
      sync_frame("t3c");
      @(negedge clk);
      check_frame("t3c", 8'h00, 8'h00, 8'h3F, 8'h6D, 7, 7, -1, 3'd7);

      // Brightness PWM and mid-dwell change
      brightness = 3'd3;
      sync_frame("t4");
      @(negedge clk);
      check_frame("t4_b3", 8'h00, 8'h00, 8'h3F, 8'h6D, 3, 3, -1, 3'd3);
      check_frame("t4_switch", 8'h00, 8'h00, 8'h3F, 8'h6D, 3, 7, 3, 3'd7);

      // Write accepted in the frame_done cycle waits a full frame
      sync_frame("t5");
      chk("t5 ready_at_fd", wr_if.wr_ready, 1'b1);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 16'h8765;
      wr_if.wr_dp    = 4'b1000;
      @(negedge clk);
      wr_if.wr_valid = 1'b0;
      chk("t5 ready_after", wr_if.wr_ready, 1'b0);
      check_frame("t5_old", 8'h00, 8'h00, 8'h3F, 8'h6D, 7, 7, -1, 3'd7);
      check_frame("t5_new", 8'hFF, 8'h07, 8'h7D, 8'h6D, 7, 7, -1, 3'd7);

      // Reset discards a pending write
      blank_lz = 1'b0;
      do_write("t6", 16'h9999, 4'b0000);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t6 rst digits", digits, 4'b1111);
      chk("t6 rst segments", segments, 8'h00);
      chk("t6 rst wr_ready", wr_if.wr_ready, 1'b1);
      chk("t6 rst frame_done", frame_done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      check_frame("t6_f0", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 7, 7, -1, 3'd7);
      check_frame("t6_f1", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 7, 7, -1, 3'd7);
      chk("t6 wr_ready_end", wr_if.wr_ready, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
